// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute-stage ALU.
//   - ALU control op-codes. These must match the encoding produced by the ALU
//     control decoder.
//   - FSM state encoding for alu_iter.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add multiplier producing the low WIDTH bits of a*b in exactly WIDTH
// iterations, with no early termination.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset
//   start_i    load operands; iterations start on the following edge
//   a_i, b_i   multiplicand / multiplier, sampled when start_i=1
//   done_o     high during the cycle whose closing edge is the last iteration
//   product_o  accumulator value after the current iteration; it is the
//              final product while done_o=1
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH-1:0] acc_next;

  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign done_o    = busy && (cnt == CW'(WIDTH - 1));
  // The top level captures the product on the last iteration edge itself, so
  // expose the post-add value rather than the registered accumulator.
  assign product_o = acc_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start_i) begin
      mcand  <= a_i;
      mplier <= b_i;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done_o) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative execute-stage ALU. Add/sub/and/or (and reserved codes) finish in
// one cycle; mul runs a WIDTH-iteration shift-add sequence. A valid/ready
// handshake lets the CPU stall fetch/decode while a mul is in flight.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | ready for a request; single-cycle ops complete from here
//   MUL   | shift-add iterations running, requests ignored
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset
//   valid_i    request, sampled only while ready_o=1
//   ready_o    idle, a request is accepted at the next edge
//   data1_i    operand A
//   data2_i    operand B
//   ALUCtrl_i  op-code (see alu_pkg)
//   data_o     registered result, held until the next completion
//   zero_o     registered, 1 when the completed result is zero
//   valid_o    one-cycle pulse marking a new data_o/zero_o
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o
);

  import alu_pkg::*;

  alu_state_t       state;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] single_res;

  assign ready_o   = (state == IDLE);
  assign accept    = valid_i && ready_o;
  assign mul_start = accept && (ALUCtrl_i == ALU_MUL);

  // Reserved codes fall into the default and produce zero.
  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      ALU_ADD: single_res = data1_i + data2_i;
      ALU_SUB: single_res = data1_i - data2_i;
      ALU_AND: single_res = data1_i & data2_i;
      ALU_OR:  single_res = data1_i | data2_i;
      default: single_res = '0;
    endcase
  end

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      data_o  <= '0;
      zero_o  <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (ALUCtrl_i == ALU_MUL) begin
              state <= MUL;
            end else begin
              data_o  <= single_res;
              zero_o  <= (single_res == '0);
              valid_o <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            data_o  <= mul_product;
            zero_o  <= (mul_product == '0);
            valid_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  ctrl;
  logic [31:0] data_o;
  logic        zero_o;
  logic        valid_o;

  int n_checks = 0;
  int n_pass   = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data1_i  (data1),
    .data2_i  (data2),
    .ALUCtrl_i(ctrl),
    .data_o   (data_o),
    .zero_o   (zero_o),
    .valid_o  (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    valid_i = v;
    ctrl    = c;
    data1   = a;
    data2   = b;
  endtask

  // Issue a mul, optionally keep an add 1+1 request asserted during it, and
  // check latency, busy window, result and single valid pulse.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit noise);
    int lat;
    int ready_bad;
    bit seen;
    drive(1'b1, 3'b100, a, b);
    tick();                              // accept edge E0
    lat = 1;
    ready_bad = 0;
    seen = 1'b0;
    if (noise) drive(1'b1, 3'b000, 32'd1, 32'd1);
    else       drive(1'b0, 3'b000, 32'd0, 32'd0);
    if (ready_o !== 1'b0) ready_bad++;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (valid_o === 1'b1) seen = 1'b1;
      else begin
        if (ready_o !== 1'b0) ready_bad++;
        tick();
        lat++;
      end
    end
    check({tag, " seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, lat, 32'd33);
    check({tag, " busy ready"}, ready_bad, 32'd0);
    check({tag, " data"}, data_o, exp);
    check({tag, " ready in valid cycle"}, {31'd0, ready_o}, 32'd1);
    if (noise) begin
      tick();                            // held add accepted at end of valid cycle
      check({tag, " b2b add data"}, data_o, 32'd2);
      check({tag, " b2b add valid"}, {31'd0, valid_o}, 32'd1);
      drive(1'b0, 3'b000, 32'd0, 32'd0);
    end
    tick();
    check({tag, " valid drops"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    int vcnt;
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst data", data_o, 32'd0);
    check("rst zero", {31'd0, zero_o}, 32'd1);
    check("rst valid", {31'd0, valid_o}, 32'd0);
    check("rst ready", {31'd0, ready_o}, 32'd1);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle data", data_o, 32'd0);
    check("idle zero", {31'd0, zero_o}, 32'd1);
    check("idle valid", {31'd0, valid_o}, 32'd0);
    check("idle ready", {31'd0, ready_o}, 32'd1);

    // back-to-back single-cycle ops
    drive(1'b1, 3'b000, 32'd5, 32'd7);
    tick();
    check("add data", data_o, 32'd12);
    check("add zero", {31'd0, zero_o}, 32'd0);
    check("add valid", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 3'b001, 32'd7, 32'd7);
    tick();
    check("sub data", data_o, 32'd0);
    check("sub zero", {31'd0, zero_o}, 32'd1);
    check("sub valid", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 3'b010, 32'h0000_F0F0, 32'h0000_0FF0);
    tick();
    check("and data", data_o, 32'h0000_00F0);
    check("and valid", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 3'b011, 32'h0000_F000, 32'h0000_000F);
    tick();
    check("or data", data_o, 32'h0000_F00F);
    check("or zero", {31'd0, zero_o}, 32'd0);
    check("or valid", {31'd0, valid_o}, 32'd1);
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    check("b2b valid drops", {31'd0, valid_o}, 32'd0);
    check("b2b data holds", data_o, 32'h0000_F00F);

    run_mul("mul 6x7", 32'd6, 32'd7, 32'd42, 1'b0);
    run_mul("mul ffx ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1);

    // reset during mul 3x3 at iteration 10
    drive(1'b1, 3'b100, 32'd3, 32'd3);
    tick();                              // E0
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    repeat (10) tick();                  // E1..E10
    check("mid-mul busy", {31'd0, ready_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort data", data_o, 32'd0);
    check("abort ready", {31'd0, ready_o}, 32'd1);
    check("abort zero", {31'd0, zero_o}, 32'd1);
    tick();
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_o === 1'b1) vcnt++;
    end
    check("abort no valid", vcnt, 32'd0);
    check("abort data held", data_o, 32'd0);
    drive(1'b1, 3'b000, 32'd1, 32'd2);
    tick();
    check("post-rst add", data_o, 32'd3);
    check("post-rst add valid", {31'd0, valid_o}, 32'd1);

    // reserved op-code
    drive(1'b1, 3'b110, 32'd5, 32'd9);
    tick();
    check("rsvd data", data_o, 32'd0);
    check("rsvd zero", {31'd0, zero_o}, 32'd1);
    check("rsvd valid", {31'd0, valid_o}, 32'd1);
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    check("rsvd single pulse", {31'd0, valid_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
